// File: rtl/rv32i_pkg.sv
// rtl/rv32i_pkg.sv - shared rv32i constants and instruction-memory arbiter types
package rv32i_pkg;

  localparam int Depth     = 256;
  localparam int ElemWidth = 8;
  localparam int DPW       = 32;
  localparam int ImemAW    = $clog2(Depth);

  localparam logic [DPW-1:0] NopInstr = 32'h00000013;

  typedef enum logic [2:0] {IDLE, RD, DRAIN, RESP, WR} imem_arb_state_e;

  // Word-aligned and the whole word fits below depth, so base+3 never wraps
  function automatic logic fetch_addr_legal(input logic [DPW-1:0] addr, input int depth);
    return (addr[1:0] == 2'b00) && (addr <= DPW'(depth - 4));
  endfunction

endpackage

// File: rtl/imem_word_buf.sv
// rtl/imem_word_buf.sv - one-entry fetched-word buffer with tag compare and write invalidate
module imem_word_buf
  import rv32i_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ImemAW-3:0] i_lookup_tag,
  output logic              o_hit,
  output logic [DPW-1:0]    o_word,
  input  logic              i_fill,
  input  logic [ImemAW-3:0] i_fill_tag,
  input  logic [DPW-1:0]    i_fill_word,
  input  logic              i_inval,
  input  logic [ImemAW-3:0] i_inval_tag
);

  logic              r_valid;
  logic [ImemAW-3:0] r_tag;
  logic [DPW-1:0]    r_word;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_tag   <= '0;
      r_word  <= '0;
    end else if (i_fill) begin
      r_valid <= 1'b1;
      r_tag   <= i_fill_tag;
      r_word  <= i_fill_word;
    end else if (i_inval && (r_tag == i_inval_tag)) begin
      r_valid <= 1'b0;
    end
  end

  assign o_hit  = r_valid && (r_tag == i_lookup_tag);
  assign o_word = r_word;

endmodule

// File: rtl/imem_fetch_arbiter.sv
// rtl/imem_fetch_arbiter.sv - byte-serial imem sharing between word fetch and program loader
// Optional word buffer: define IMEM_WORD_BUF_EN
module imem_fetch_arbiter
  import rv32i_pkg::*;
#(
  parameter int MemDepth = Depth,
  parameter bit LdFair   = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 fetch_req_i,
  input  logic [DPW-1:0]       fetch_addr_i,
  output logic                 fetch_ready_o,
  output logic                 fetch_valid_o,
  output logic [DPW-1:0]       fetch_instr_o,
  output logic                 fetch_err_o,
  input  logic                 ld_valid_i,
  input  logic [DPW-1:0]       ld_addr_i,
  input  logic [ElemWidth-1:0] ld_data_i,
  output logic                 ld_ready_o,
  output logic                 mem_en_o,
  output logic                 mem_we_o,
  output logic [ImemAW-1:0]    mem_addr_o,
  output logic [ElemWidth-1:0] mem_wdata_o,
  input  logic [ElemWidth-1:0] mem_rdata_i
);

  imem_arb_state_e            r_state;
  logic [1:0]                 r_beat;
  logic [3*ElemWidth-1:0]     r_asm;
  logic                       r_fair;
  logic                       r_mem_en;
  logic                       r_mem_we;
  logic [ImemAW-1:0]          r_mem_addr;
  logic [ElemWidth-1:0]       r_mem_wdata;
  logic                       r_valid;
  logic                       r_err;
  logic [DPW-1:0]             r_instr;

  logic                       w_idle;
  logic                       w_ld_grant;
  logic                       w_fetch_grant;
  logic                       w_fetch_legal;
  logic                       w_ld_in_range;
  logic                       w_buf_hit;
  logic [DPW-1:0]             w_buf_word;
  logic [DPW-1:0]             w_asm_word;

  assign w_idle        = (r_state == IDLE);
  assign ld_ready_o    = w_idle && !(r_fair && fetch_req_i);
  assign w_ld_grant    = ld_ready_o && ld_valid_i;
  assign fetch_ready_o = w_idle && !w_ld_grant;
  assign w_fetch_grant = fetch_ready_o && fetch_req_i;
  assign w_fetch_legal = fetch_addr_legal(fetch_addr_i, MemDepth);
  assign w_ld_in_range = (ld_addr_i < DPW'(MemDepth));
  // Byte 3 arrives in DRAIN straight off the memory port
  assign w_asm_word    = {mem_rdata_i, r_asm};

`ifdef IMEM_WORD_BUF_EN
  imem_word_buf u_word_buf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_lookup_tag (fetch_addr_i[ImemAW-1:2]),
    .o_hit        (w_buf_hit),
    .o_word       (w_buf_word),
    .i_fill       (r_state == DRAIN),
    .i_fill_tag   (r_mem_addr[ImemAW-1:2]),
    .i_fill_word  (w_asm_word),
    .i_inval      ((r_state == WR) && r_mem_en),
    .i_inval_tag  (r_mem_addr[ImemAW-1:2])
  );
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_word = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_beat      <= 2'd0;
      r_asm       <= '0;
      r_fair      <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_valid     <= 1'b0;
      r_err       <= 1'b0;
      r_instr     <= '0;
    end else begin
      r_valid  <= 1'b0;
      r_err    <= 1'b0;
      r_mem_en <= 1'b0;
      r_mem_we <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (w_ld_grant) begin
            r_state     <= WR;
            r_mem_en    <= w_ld_in_range;
            r_mem_we    <= w_ld_in_range;
            r_mem_addr  <= ld_addr_i[ImemAW-1:0];
            r_mem_wdata <= ld_data_i;
          end else if (w_fetch_grant) begin
            r_fair <= 1'b0;
            if (!w_fetch_legal) begin
              r_state <= RESP;
              r_valid <= 1'b1;
              r_err   <= 1'b1;
              r_instr <= NopInstr;
            end else if (w_buf_hit) begin
              r_state <= RESP;
              r_valid <= 1'b1;
              r_instr <= w_buf_word;
            end else begin
              r_state    <= RD;
              r_beat     <= 2'd0;
              r_mem_en   <= 1'b1;
              r_mem_addr <= fetch_addr_i[ImemAW-1:0];
            end
          end
        end
        RD: begin
          // Read data lags the strobe by one cycle, so beat b lands byte b-1
          case (r_beat)
            2'd1:    r_asm[ElemWidth-1:0]             <= mem_rdata_i;
            2'd2:    r_asm[2*ElemWidth-1:ElemWidth]   <= mem_rdata_i;
            2'd3:    r_asm[3*ElemWidth-1:2*ElemWidth] <= mem_rdata_i;
            default: ;
          endcase
          if (r_beat == 2'd3) begin
            r_state <= DRAIN;
          end else begin
            r_beat     <= r_beat + 2'd1;
            r_mem_en   <= 1'b1;
            r_mem_addr <= r_mem_addr + ImemAW'(1);
          end
        end
        DRAIN: begin
          r_state <= RESP;
          r_valid <= 1'b1;
          r_instr <= w_asm_word;
        end
        RESP: begin
          r_state <= IDLE;
        end
        WR: begin
          r_state <= IDLE;
          if (LdFair && fetch_req_i) r_fair <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign fetch_valid_o = r_valid;
  assign fetch_err_o   = r_err;
  assign fetch_instr_o = r_instr;
  assign mem_en_o      = r_mem_en;
  assign mem_we_o      = r_mem_we;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// tb/tb_imem_fetch_arbiter.sv - self-checking bench for imem_fetch_arbiter
module tb_imem_fetch_arbiter;
  import rv32i_pkg::*;

  localparam int MD = Depth;
`ifdef IMEM_WORD_BUF_EN
  localparam bit BufEn = 1'b1;
`else
  localparam bit BufEn = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fetch_req, fetch_ready, fetch_valid, fetch_err;
  logic [31:0] fetch_addr, fetch_instr;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic [7:0]  ld_data;
  logic        mem_en, mem_we;
  logic [7:0]  mem_addr, mem_wdata, mem_rdata;

  logic        f0_req, f0_ready, f0_valid, f0_err, f0_ldv, f0_ldr, f0_en, f0_we;
  logic [31:0] f0_addr, f0_instr, f0_lda;
  logic [7:0]  f0_ldd, f0_maddr, f0_wdata;

  imem_fetch_arbiter #(.MemDepth(MD), .LdFair(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_i(fetch_req), .fetch_addr_i(fetch_addr), .fetch_ready_o(fetch_ready),
    .fetch_valid_o(fetch_valid), .fetch_instr_o(fetch_instr), .fetch_err_o(fetch_err),
    .ld_valid_i(ld_valid), .ld_addr_i(ld_addr), .ld_data_i(ld_data), .ld_ready_o(ld_ready),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  imem_fetch_arbiter #(.MemDepth(MD), .LdFair(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .fetch_req_i(f0_req), .fetch_addr_i(f0_addr), .fetch_ready_o(f0_ready),
    .fetch_valid_o(f0_valid), .fetch_instr_o(f0_instr), .fetch_err_o(f0_err),
    .ld_valid_i(f0_ldv), .ld_addr_i(f0_lda), .ld_data_i(f0_ldd), .ld_ready_o(f0_ldr),
    .mem_en_o(f0_en), .mem_we_o(f0_we), .mem_addr_o(f0_maddr), .mem_wdata_o(f0_wdata),
    .mem_rdata_i(8'h00)
  );

  logic [7:0] mem [MD];
  logic [7:0] ref_mem [MD];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      else        mem_rdata     <= mem[mem_addr];
    end
  end

  int pass_cnt = 0;
  int chk_cnt  = 0;
  bit          m_bvalid = 1'b0;
  logic [29:0] m_btag   = '0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s actual=%h required=%h", nm, act, exp);
  endtask

  task automatic do_load(input logic [31:0] a, input logic [7:0] d);
    @(negedge clk);
    ld_valid = 1'b1; ld_addr = a; ld_data = d;
    #1 check("ld_ready", {31'd0, ld_ready}, 32'd1);
    @(posedge clk);
    #1 ld_valid = 1'b0;
    check("ld_mem_en", {31'd0, mem_en}, {31'd0, a < MD});
    if (a < MD) begin
      check("ld_wr_port", {15'd0, mem_we, mem_addr, mem_wdata}, {15'd0, 1'b1, a[7:0], d});
      ref_mem[a] = d;
      if (m_bvalid && m_btag == a[31:2]) m_bvalid = 1'b0;
    end
    @(posedge clk);
  endtask

  // Reference: legality, buffer hit and the assembled word come from the spec's rules
  task automatic model_fetch(input logic [31:0] a, output logic [31:0] instr, output logic err,
                             output int lat, output int nen);
    if (a[1:0] != 2'b00 || a > MD - 4) begin
      instr = NopInstr; err = 1'b1; lat = 1; nen = 0;
    end else begin
      instr = {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
      err = 1'b0;
      if (BufEn && m_bvalid && m_btag == a[31:2]) begin
        lat = 1; nen = 0;
      end else begin
        lat = 6; nen = 4;
        if (BufEn) begin m_bvalid = 1'b1; m_btag = a[31:2]; end
      end
    end
  endtask

  task automatic run_fetch(input logic [31:0] a, output logic [31:0] got);
    logic [31:0] ei; logic ee; int el, en;
    int lat, nen; bit bad; logic err;
    logic [7:0] ea;
    lat = 0; nen = 0; bad = 1'b0; err = 1'b0; got = '0;
    model_fetch(a, ei, ee, el, en);
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = a;
    #1 check("fetch_ready_idle", {31'd0, fetch_ready}, 32'd1);
    @(posedge clk);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      fetch_req = 1'b0;
      #1;
      if (fetch_ready) bad = 1'b1;
      if (mem_en) begin
        nen++;
        ea = a[7:0] + 8'(c - 1);
        if (mem_we || mem_addr != ea || c > 4) bad = 1'b1;
      end
      if (fetch_valid) begin
        lat = c; got = fetch_instr; err = fetch_err;
        break;
      end
    end
    check("fetch_latency", lat, el);
    check("fetch_instr", got, ei);
    check("fetch_err", {31'd0, err}, {31'd0, ee});
    check("fetch_mem_reads", nen, en);
    check("fetch_busy_port", {31'd0, bad}, 32'd0);
    @(posedge clk);
  endtask

  typedef struct {
    bit          is_load;
    logic [31:0] addr;
    logic [7:0]  data;
    bit          fixed;
    logic [31:0] exp_instr;
  } vec_t;
  vec_t tbl [15];

  initial begin
    logic [31:0] got;
    logic [3:0]  pat;
    logic [4:0]  pat0;
    int ng, nw, nv;
    bit idle_ok;

    for (int i = 0; i < MD; i++) mem[i] = 8'($urandom);
    mem[0] = 8'h03; mem[1] = 8'h22; mem[2] = 8'h02; mem[3] = 8'h00;
    mem[8] = 8'h11; mem[9] = 8'h22; mem[10] = 8'h33; mem[11] = 8'h44;
    for (int i = 0; i < MD; i++) ref_mem[i] = mem[i];

    rst_n = 1'b0;
    fetch_req = 0; fetch_addr = 0; ld_valid = 0; ld_addr = 0; ld_data = 0;
    f0_req = 0; f0_addr = 0; f0_ldv = 0; f0_lda = 0; f0_ldd = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    check("rst_outputs", {28'd0, fetch_valid, fetch_err, mem_en, mem_we}, 32'd0);
    check("rst_instr", fetch_instr, 32'd0);
    check("rst_mem_addr", {24'd0, mem_addr}, 32'd0);
    check("rst_readies", {30'd0, fetch_ready, ld_ready}, 32'd3);
    rst_n = 1'b1;
    @(posedge clk);

    tbl[0]  = '{1'b0, 32'h00, 8'h00, 1'b1, 32'h00022203};
    tbl[1]  = '{1'b0, 32'h06, 8'h00, 1'b1, NopInstr};
    tbl[2]  = '{1'b0, MD - 2, 8'h00, 1'b1, NopInstr};
    tbl[3]  = '{1'b1, 32'h10, 8'h33, 1'b0, 32'h0};
    tbl[4]  = '{1'b1, 32'h11, 8'h83, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 32'h12, 8'h42, 1'b0, 32'h0};
    tbl[6]  = '{1'b1, 32'h13, 8'h00, 1'b0, 32'h0};
    tbl[7]  = '{1'b0, 32'h10, 8'h00, 1'b1, 32'h00428333};
    tbl[8]  = '{1'b1, MD,     8'h77, 1'b0, 32'h0};
    tbl[9]  = '{1'b0, 32'h08, 8'h00, 1'b1, 32'h44332211};
    tbl[10] = '{1'b0, 32'h08, 8'h00, 1'b1, 32'h44332211};
    tbl[11] = '{1'b1, 32'h0B, 8'hA5, 1'b0, 32'h0};
    tbl[12] = '{1'b0, 32'h08, 8'h00, 1'b1, 32'hA5332211};
    tbl[13] = '{1'b0, MD - 4, 8'h00, 1'b0, 32'h0};
    tbl[14] = '{1'b0, MD,     8'h00, 1'b1, NopInstr};

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].is_load) do_load(tbl[i].addr, tbl[i].data);
      else begin
        run_fetch(tbl[i].addr, got);
        if (tbl[i].fixed) check($sformatf("tbl_instr_%0d", i), got, tbl[i].exp_instr);
      end
    end

    // Fair arbitration: both requesters held, grants must alternate loader/fetch
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h20; ld_valid = 1'b1; ld_addr = 32'h40; ld_data = 8'h5A;
    pat = '0; ng = 0;
    for (int c = 0; c < 60 && ng < 4; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (ld_ready && ld_valid) begin
        pat = {pat[2:0], 1'b0}; ng++; ref_mem[32'h40] = 8'h5A;
      end else if (fetch_ready && fetch_req) begin
        pat = {pat[2:0], 1'b1}; ng++;
      end
    end
    @(posedge clk);
    #1 fetch_req = 1'b0; ld_valid = 1'b0;
    check("fair_grant_count", ng, 4);
    check("fair_grant_order", {28'd0, pat}, 32'h5);
    idle_ok = 1'b0;
    for (int c = 0; c < 12 && !idle_ok; c++) begin
      @(negedge clk); #1;
      if (fetch_ready) idle_ok = 1'b1;
    end
    check("fair_return_idle", {31'd0, idle_ok}, 32'd1);
    if (BufEn) begin m_bvalid = 1'b1; m_btag = 30'h8; end
    @(posedge clk);

    // Loader priority: all four loader bytes precede the fetch
    @(negedge clk);
    f0_req = 1'b1; f0_addr = 32'h0; f0_ldv = 1'b1; f0_lda = 32'h30; f0_ldd = 8'h99;
    pat0 = '0; ng = 0; nw = 0;
    for (int c = 0; c < 60 && ng < 5; c++) begin
      if (c > 0) @(negedge clk);
      if (nw == 4) f0_ldv = 1'b0;
      #1;
      if (f0_ldr && f0_ldv) begin
        pat0 = {pat0[3:0], 1'b0}; ng++; nw++;
      end else if (f0_ready && f0_req) begin
        pat0 = {pat0[3:0], 1'b1}; ng++;
      end
    end
    @(posedge clk);
    #1 f0_req = 1'b0;
    check("prio_grant_order", {27'd0, pat0}, 32'h1);
    repeat (8) @(posedge clk);

    // Reset in cycle 3 of a fetch abandons it
    @(negedge clk);
    fetch_req = 1'b1; fetch_addr = 32'h0;
    @(posedge clk);
    @(negedge clk); fetch_req = 1'b0;
    @(negedge clk);
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_outputs", {30'd0, fetch_valid, mem_en}, 32'd0);
    check("midrst_instr", fetch_instr, 32'd0);
    check("midrst_idle", {31'd0, fetch_ready}, 32'd1);
    m_bvalid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk); #1;
      if (fetch_valid || mem_en) nv++;
    end
    check("midrst_no_response", nv, 0);

    for (int it = 0; it < 40; it++) begin
      int r;
      logic [31:0] a;
      r = $urandom_range(0, 9);
      if (r < 4) do_load(32'($urandom_range(0, MD + 7)), 8'($urandom));
      else begin
        if (r < 6)      a = 32'($urandom_range(0, 7)) * 4;
        else if (r < 8) a = 32'($urandom_range(0, MD / 4 - 1)) * 4;
        else if (r < 9) a = 32'($urandom_range(0, MD / 4 - 1)) * 4 + 32'($urandom_range(1, 3));
        else            a = MD + 32'($urandom_range(0, 15)) * 4;
        run_fetch(a, got);
      end
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
